// File: rtl/pet_stats_core.sv
// ----------------------------------------------------------------------------
// pet_stats_core : saturating pet stat counters with tick-driven decay,
// edge-triggered replenish events and an AWAKE/SLEEP/SICK mode FSM.
// Optional feature macro: PET_AUTO_WAKE_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pet_stats_core #(
    parameter int VAL_W       = 3,
    parameter int TICK_DIV    = 5000,
    parameter int FOOD_DECAY  = 4,
    parameter int SLEEP_DECAY = 6,
    parameter int FUN_DECAY   = 3,
    parameter int STEP        = 2,
    parameter int SICK_THR    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             feeding,
    input  logic             healing,
    input  logic             light_out,
    input  logic             echo_sig,
    output logic [VAL_W-1:0] foodValue,
    output logic [VAL_W-1:0] sleepValue,
    output logic [VAL_W-1:0] funValue,
    output logic [VAL_W-1:0] happyValue,
    output logic [VAL_W-1:0] healthValue,
    output logic [1:0]       mode,
    output logic             tick
);

    localparam int TICK_CW  = $clog2(TICK_DIV);
    localparam int FOOD_CW  = (FOOD_DECAY  > 1) ? $clog2(FOOD_DECAY)  : 1;
    localparam int SLEEP_CW = (SLEEP_DECAY > 1) ? $clog2(SLEEP_DECAY) : 1;
    localparam int FUN_CW   = (FUN_DECAY   > 1) ? $clog2(FUN_DECAY)   : 1;

    localparam logic [TICK_CW-1:0]  TICK_LAST  = TICK_CW'(TICK_DIV - 1);
    localparam logic [FOOD_CW-1:0]  FOOD_LAST  = FOOD_CW'(FOOD_DECAY - 1);
    localparam logic [SLEEP_CW-1:0] SLEEP_LAST = SLEEP_CW'(SLEEP_DECAY - 1);
    localparam logic [FUN_CW-1:0]   FUN_LAST   = FUN_CW'(FUN_DECAY - 1);

    localparam logic [VAL_W-1:0] MAXV   = '1;
    localparam logic [VAL_W-1:0] THR_V  = VAL_W'(SICK_THR);
    localparam logic [VAL_W:0]   STEP_V = (VAL_W+1)'(STEP);
    localparam logic [VAL_W:0]   ONE_V  = (VAL_W+1)'(1);
    localparam logic [VAL_W:0]   ZERO_V = '0;

    typedef enum logic [1:0] {
        ST_AWAKE = 2'b00,
        ST_SLEEP = 2'b01,
        ST_SICK  = 2'b10
    } mode_e;

    // Result is sat(v - dec + inc), clamped to 0..MAXV only at the end.
    function automatic logic [VAL_W-1:0] sat_upd(input logic [VAL_W-1:0] v,
                                                 input logic             dec,
                                                 input logic [VAL_W:0]   inc);
        logic [VAL_W+1:0] s;
        s = {2'b00, v} + {1'b0, inc};
        if (dec && (s != '0))
            s = s - 1'b1;
        if (s > {2'b00, MAXV})
            return MAXV;
        return s[VAL_W-1:0];
    endfunction

    mode_e               mode_q, mode_d;
    logic [TICK_CW-1:0]  presc_q, presc_d;
    logic [FOOD_CW-1:0]  food_tmr_q, food_tmr_d;
    logic [SLEEP_CW-1:0] sleep_tmr_q, sleep_tmr_d;
    logic [FUN_CW-1:0]   fun_tmr_q, fun_tmr_d;
    logic [VAL_W-1:0]    food_q, food_d;
    logic [VAL_W-1:0]    sleep_q, sleep_d;
    logic [VAL_W-1:0]    fun_q, fun_d;
    logic [VAL_W-1:0]    health_q, health_d;
    logic [VAL_W-1:0]    happy_q, happy_d;
    logic                feed_q, feed_prev_q;
    logic                heal_q, heal_prev_q;
    logic                echo_q, echo_prev_q;
    logic                light_q;

    logic                tick_w;
    logic                feed_edge, heal_edge, echo_edge;
    logic                food_dec, sleep_dec, fun_dec, health_dec;
    logic [VAL_W:0]      food_inc, sleep_inc, fun_inc, health_inc;
    logic [VAL_W+1:0]    happy_sum;
    logic                sleep_blocked;

`ifdef PET_AUTO_WAKE_EN
    logic                wake_blk_q, wake_blk_d;
    assign sleep_blocked = wake_blk_q;
`else
    assign sleep_blocked = 1'b0;
`endif

    assign feed_edge = feed_q & ~feed_prev_q;
    assign heal_edge = heal_q & ~heal_prev_q;
    assign echo_edge = echo_q & ~echo_prev_q;

    always_comb begin
        tick_w      = (presc_q == TICK_LAST);
        presc_d     = tick_w ? '0 : presc_q + 1'b1;
        food_tmr_d  = food_tmr_q;
        sleep_tmr_d = sleep_tmr_q;
        fun_tmr_d   = fun_tmr_q;
        food_dec    = 1'b0;
        sleep_dec   = 1'b0;
        fun_dec     = 1'b0;
        health_dec  = 1'b0;
        sleep_inc   = ZERO_V;

        if (tick_w) begin
            if (food_tmr_q == FOOD_LAST) begin
                food_tmr_d = '0;
                food_dec   = 1'b1;
            end else begin
                food_tmr_d = food_tmr_q + 1'b1;
            end

            // While asleep the sleep timer holds and the level recovers instead.
            if (mode_q == ST_SLEEP) begin
                sleep_inc = ONE_V;
            end else if (sleep_tmr_q == SLEEP_LAST) begin
                sleep_tmr_d = '0;
                sleep_dec   = 1'b1;
            end else begin
                sleep_tmr_d = sleep_tmr_q + 1'b1;
            end

            if (mode_q == ST_AWAKE) begin
                if (fun_tmr_q == FUN_LAST) begin
                    fun_tmr_d = '0;
                    fun_dec   = 1'b1;
                end else begin
                    fun_tmr_d = fun_tmr_q + 1'b1;
                end
            end

            health_dec = (food_q == '0) || (sleep_q == '0);
        end

        food_inc   = (feed_edge && (mode_q == ST_AWAKE)) ? STEP_V : ZERO_V;
        fun_inc    = (echo_edge && (mode_q == ST_AWAKE)) ? STEP_V : ZERO_V;
        health_inc = heal_edge ? STEP_V : ZERO_V;

        food_d   = sat_upd(food_q,   food_dec,   food_inc);
        sleep_d  = sat_upd(sleep_q,  sleep_dec,  sleep_inc);
        fun_d    = sat_upd(fun_q,    fun_dec,    fun_inc);
        health_d = sat_upd(health_q, health_dec, health_inc);

        happy_sum = {2'b00, food_q} + {2'b00, sleep_q} + {1'b0, fun_q, 1'b0};
        happy_d   = happy_sum[VAL_W+1:2];
    end

    // Mode next-state, decided on the next-state stat values.
    always_comb begin
        mode_d = mode_q;
`ifdef PET_AUTO_WAKE_EN
        wake_blk_d = wake_blk_q;
        if (!light_q)
            wake_blk_d = 1'b0;
`endif
        if (health_d <= THR_V) begin
            mode_d = ST_SICK;
        end else begin
            case (mode_q)
                ST_SICK: mode_d = ST_AWAKE;
                ST_AWAKE: begin
                    if (light_q && !sleep_blocked)
                        mode_d = ST_SLEEP;
                end
                ST_SLEEP: begin
                    if (!light_q) begin
                        mode_d = ST_AWAKE;
                    end
`ifdef PET_AUTO_WAKE_EN
                    else if (sleep_d == MAXV) begin
                        mode_d     = ST_AWAKE;
                        wake_blk_d = 1'b1;
                    end
`endif
                end
                default: mode_d = ST_AWAKE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q <= ST_AWAKE;
        end else begin
            mode_q <= mode_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc_q     <= '0;
            food_tmr_q  <= '0;
            sleep_tmr_q <= '0;
            fun_tmr_q   <= '0;
            food_q      <= MAXV;
            sleep_q     <= MAXV;
            fun_q       <= MAXV;
            health_q    <= MAXV;
            happy_q     <= MAXV;
            feed_q      <= 1'b0;
            feed_prev_q <= 1'b0;
            heal_q      <= 1'b0;
            heal_prev_q <= 1'b0;
            echo_q      <= 1'b0;
            echo_prev_q <= 1'b0;
            light_q     <= 1'b0;
`ifdef PET_AUTO_WAKE_EN
            wake_blk_q  <= 1'b0;
`endif
        end else begin
            presc_q     <= presc_d;
            food_tmr_q  <= food_tmr_d;
            sleep_tmr_q <= sleep_tmr_d;
            fun_tmr_q   <= fun_tmr_d;
            food_q      <= food_d;
            sleep_q     <= sleep_d;
            fun_q       <= fun_d;
            health_q    <= health_d;
            happy_q     <= happy_d;
            feed_q      <= feeding;
            feed_prev_q <= feed_q;
            heal_q      <= healing;
            heal_prev_q <= heal_q;
            echo_q      <= echo_sig;
            echo_prev_q <= echo_q;
            light_q     <= light_out;
`ifdef PET_AUTO_WAKE_EN
            wake_blk_q  <= wake_blk_d;
`endif
        end
    end

    assign foodValue   = food_q;
    assign sleepValue  = sleep_q;
    assign funValue    = fun_q;
    assign happyValue  = happy_q;
    assign healthValue = health_q;
    assign mode        = mode_q;
    assign tick        = tick_w;

endmodule

`default_nettype wire

// File: tb/tb_pet_stats_core.sv
// ----------------------------------------------------------------------------
// tb_pet_stats_core : directed + randomized checks of pet_stats_core against a
// behavioural model of the pet rules.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_pet_stats_core;

    localparam int VAL_W       = 3;
    localparam int TICK_DIV    = 4;
    localparam int FOOD_DECAY  = 2;
    localparam int SLEEP_DECAY = 3;
    localparam int FUN_DECAY   = 1;
    localparam int STEP        = 2;
    localparam int SICK_THR    = 2;
    localparam int MAXV        = (1 << VAL_W) - 1;
`ifdef PET_AUTO_WAKE_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic             clk       = 1'b0;
    logic             rst       = 1'b0;
    logic             feeding   = 1'b0;
    logic             healing   = 1'b0;
    logic             light_out = 1'b0;
    logic             echo_sig  = 1'b0;
    logic [VAL_W-1:0] foodValue, sleepValue, funValue, happyValue, healthValue;
    logic [1:0]       mode;
    logic             tick;

    always #5 clk = ~clk;

    pet_stats_core #(
        .VAL_W(VAL_W), .TICK_DIV(TICK_DIV), .FOOD_DECAY(FOOD_DECAY),
        .SLEEP_DECAY(SLEEP_DECAY), .FUN_DECAY(FUN_DECAY), .STEP(STEP),
        .SICK_THR(SICK_THR)
    ) dut (
        .clk(clk), .rst(rst), .feeding(feeding), .healing(healing),
        .light_out(light_out), .echo_sig(echo_sig),
        .foodValue(foodValue), .sleepValue(sleepValue), .funValue(funValue),
        .happyValue(happyValue), .healthValue(healthValue),
        .mode(mode), .tick(tick)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference pet: levels, ticks elapsed per stat, cycles since reset.
    int m_food, m_sleep, m_fun, m_health, m_happy, m_mode;
    int t_food, t_sleep, t_fun, cyc;
    bit s_feed, p_feed, s_heal, p_heal, s_echo, p_echo, s_light, m_blk;

    function automatic int sat(input int v);
        if (v < 0) return 0;
        if (v > MAXV) return MAXV;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input int exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_food = MAXV; m_sleep = MAXV; m_fun = MAXV; m_health = MAXV; m_happy = MAXV;
        m_mode = 0; t_food = 0; t_sleep = 0; t_fun = 0; cyc = 0;
        s_feed = 0; p_feed = 0; s_heal = 0; p_heal = 0; s_echo = 0; p_echo = 0;
        s_light = 0; m_blk = 0;
    endtask

    task automatic model_step();
        bit tk, fe, he, ee, fd, sd, ud, hd, si;
        int nf, ns, nu, nh, nm;
        tk = ((cyc + 1) % TICK_DIV) == 0;
        fe = s_feed && !p_feed;
        he = s_heal && !p_heal;
        ee = s_echo && !p_echo;
        fd = 0; sd = 0; ud = 0; hd = 0; si = 0;
        if (tk) begin
            t_food++;
            if (t_food == FOOD_DECAY) begin t_food = 0; fd = 1; end
            if (m_mode == 1) si = 1;
            else begin
                t_sleep++;
                if (t_sleep == SLEEP_DECAY) begin t_sleep = 0; sd = 1; end
            end
            if (m_mode == 0) begin
                t_fun++;
                if (t_fun == FUN_DECAY) begin t_fun = 0; ud = 1; end
            end
            hd = (m_food == 0) || (m_sleep == 0);
        end
        nf = sat(m_food - fd + ((fe && m_mode == 0) ? STEP : 0));
        ns = sat(m_sleep - sd + si);
        nu = sat(m_fun - ud + ((ee && m_mode == 0) ? STEP : 0));
        nh = sat(m_health - hd + (he ? STEP : 0));
        nm = m_mode;
        if (!s_light) m_blk = 0;
        if (nh <= SICK_THR) nm = 2;
        else if (m_mode == 2) nm = 0;
        else if (m_mode == 0) begin
            if (s_light && !m_blk) nm = 1;
        end else begin
            if (!s_light) nm = 0;
            else if (AUTO && ns == MAXV) begin nm = 0; m_blk = 1; end
        end
        m_happy  = (m_food + m_sleep + 2 * m_fun) / 4;
        m_food   = nf; m_sleep = ns; m_fun = nu; m_health = nh; m_mode = nm;
        cyc++;
        p_feed = s_feed; s_feed = feeding;
        p_heal = s_heal; s_heal = healing;
        p_echo = s_echo; s_echo = echo_sig;
        s_light = light_out;
    endtask

    task automatic check_all();
        chk("food",   foodValue,   m_food);
        chk("sleep",  sleepValue,  m_sleep);
        chk("fun",    funValue,    m_fun);
        chk("health", healthValue, m_health);
        chk("happy",  happyValue,  m_happy);
        chk("mode",   mode,        m_mode);
        chk("tick",   tick,        (((cyc + 1) % TICK_DIV) == 0) ? 1 : 0);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    // Asynchronous reset in the middle of a cycle, checked while still asserted.
    task automatic do_reset();
        @(negedge clk);
        #2 rst = 1'b0;
        feeding = 0; healing = 0; light_out = 0; echo_sig = 0;
        #1 model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int guard;
        // Idle after reset: two fun decays, one food decay.
        do_reset();
        repeat (8) cycle();
        chk("idle_fun", funValue, 5);
        chk("idle_food", foodValue, 6);
        chk("idle_sleep", sleepValue, 7);
        chk("idle_mode", mode, 0);

        // Feeding edge lands on the food decay edge: 6 - 1 + 2 saturates at 7.
        do_reset();
        repeat (14) cycle();
        feeding = 1;
        repeat (2) cycle();
        chk("feed_on_decay", foodValue, 7);
        feeding = 0;

        // Fun drained to 0, then echo held high counts once.
        repeat (16) cycle();
        chk("fun_zero", funValue, 0);
        echo_sig = 1;
        repeat (2) cycle();
        chk("echo_once", funValue, 2);
        repeat (18) cycle();
        echo_sig = 0;
        cycle();

        // Lights off: sleep, fun frozen, feeding ignored.
        do_reset();
        light_out = 1;
        repeat (2) cycle();
        chk("sleep_mode", mode, 1);
        for (int i = 0; i < 30; i++) begin
            feeding = (i % 5) == 2;
            cycle();
        end
        feeding = 0;
        light_out = 0;
        repeat (3) cycle();

        // Starve until SICK, then heal back to AWAKE.
        do_reset();
        guard = 0;
        while (m_mode != 2 && guard < 200) begin
            cycle();
            guard++;
        end
        chk("sick_reached", mode, 2);
        chk("sick_health", healthValue, 2);
        healing = 1;
        repeat (2) cycle();
        chk("heal_health", healthValue, 4);
        chk("heal_mode", mode, 0);
        healing = 0;
        repeat (4) cycle();

        // Lights held off while sleep refills to MAXV.
        do_reset();
        repeat (12) cycle();
        light_out = 1;
        repeat (20) cycle();
        chk("full_sleep_mode", mode, AUTO ? 0 : 1);
        light_out = 0;
        repeat (3) cycle();
        light_out = 1;
        repeat (3) cycle();

        // Randomized traffic with one mid-run reset.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            feeding  = ($urandom_range(0, 3) == 0);
            healing  = ($urandom_range(0, 5) == 0);
            echo_sig = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 39) == 0) light_out = ~light_out;
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
